// File: rtl/mmc1_serial_loader.sv
// mmc1_serial_loader: turns one parallel register request into the CPU-bus
// write sequence an MMC1 needs on its 5-bit serial port. The sequence is an
// optional reset write (D7=1) followed by five single-bit writes, LSB first.
// Writes are separated by idle gaps because the mapper ignores a write that
// lands on the cycle right after another write.
//
// Request handshake: a request transfers on a rising ck edge where both
// req_valid and req_ready are high. req_ready is high only in IDLE. While the
// loader is busy, req_valid and the request fields are not sampled. The host
// must hold req_reg/req_data/req_reset stable while req_valid is high and
// req_ready is low.
module mmc1_serial_loader #(
    parameter int STROBE_CYCLES = 1,  // cycles bus_we stays high per write (>=1)
    parameter int GAP_CYCLES    = 2,  // low cycles between writes (>=1)
    parameter int RESET_FIRST   = 1   // 1: every data request starts with a reset write
) (
    input  logic       ck,
    input  logic       nres,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_reg,
    input  logic [4:0] req_data,
    input  logic       req_reset,
    output logic       bus_we,
    output logic [1:0] bus_a,
    output logic [7:0] bus_d,
    output logic       busy,
    output logic       done,
    output logic [2:0] wr_left,
    output logic [1:0] state_dbg
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STROBE = 2'd1;
    localparam logic [1:0] GAP    = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    localparam logic [15:0] STROBE_LAST = 16'(STROBE_CYCLES - 1);
    localparam logic [15:0] GAP_LAST    = 16'(GAP_CYCLES - 1);

    localparam logic [7:0] RESET_WRITE = 8'h80;

    logic [1:0]  state;
    logic [15:0] cnt;      // cycles spent in the current STROBE or GAP
    logic [4:0]  data_sr;  // data bits not yet placed on the bus, next bit at [0]

    assign state_dbg = state;

    // Sequencer: handshake, write timing, bus drive and write bookkeeping.
    always_ff @(posedge ck) begin
        if (!nres) begin
            state     <= IDLE;
            cnt       <= '0;
            data_sr   <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            bus_we    <= 1'b0;
            bus_a     <= '0;
            bus_d     <= '0;
            wr_left   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        state     <= STROBE;
                        cnt       <= '0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        bus_we    <= 1'b1;
                        bus_a     <= req_reg;
                        if (req_reset) begin
                            // Reset-only request: a single D7 write, data unused.
                            wr_left <= 3'd1;
                            bus_d   <= RESET_WRITE;
                            data_sr <= req_data;
                        end else if (RESET_FIRST != 0) begin
                            wr_left <= 3'd6;
                            bus_d   <= RESET_WRITE;
                            data_sr <= req_data;
                        end else begin
                            // No reset write: bit 0 goes out immediately.
                            wr_left <= 3'd5;
                            bus_d   <= {7'b0, req_data[0]};
                            data_sr <= {1'b0, req_data[4:1]};
                        end
                    end
                end
                STROBE: begin
                    if (cnt == STROBE_LAST) begin
                        bus_we  <= 1'b0;
                        cnt     <= '0;
                        wr_left <= wr_left - 3'd1;
                        if (wr_left == 3'd1) begin
                            // Last write: no trailing gap.
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        // Address/data only move on the edge the strobe rises.
                        state   <= STROBE;
                        cnt     <= '0;
                        bus_we  <= 1'b1;
                        bus_d   <= {7'b0, data_sr[0]};
                        data_sr <= {1'b0, data_sr[4:1]};
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                FINISH: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    bus_we    <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmc1_serial_loader.sv
// Bench for mmc1_serial_loader: three instances (default timing, no reset
// write, 2-cycle strobes with 1-cycle gaps) checked every cycle against a
// write-list schedule model, plus literal expectations for the directed cases.
module tb_mmc1_serial_loader;

    typedef struct packed {
        logic       we;
        logic [1:0] a;
        logic [7:0] d;
        logic [2:0] wl;
        logic       dn;
        logic       rdy;
    } exp_t;

    // clock / reset
    logic ck;
    logic nres;
    initial ck = 1'b0;
    always #5 ck = ~ck;

    logic [2:0]      req_valid;
    logic [2:0]      req_reset;
    logic [2:0][1:0] req_reg;
    logic [2:0][4:0] req_data;
    logic [2:0]      req_ready;
    logic [2:0]      bus_we;
    logic [2:0][1:0] bus_a;
    logic [2:0][7:0] bus_d;
    logic [2:0]      busy;
    logic [2:0]      done;
    logic [2:0][2:0] wr_left;
    logic [2:0][1:0] state_dbg;

    int  vectors;
    int  miscompares;
    logic chk_en;

    mmc1_serial_loader u0 (
        .ck(ck), .nres(nres), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_reg(req_reg[0]), .req_data(req_data[0]), .req_reset(req_reset[0]),
        .bus_we(bus_we[0]), .bus_a(bus_a[0]), .bus_d(bus_d[0]), .busy(busy[0]),
        .done(done[0]), .wr_left(wr_left[0]), .state_dbg(state_dbg[0])
    );

    mmc1_serial_loader #(.RESET_FIRST(0)) u1 (
        .ck(ck), .nres(nres), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_reg(req_reg[1]), .req_data(req_data[1]), .req_reset(req_reset[1]),
        .bus_we(bus_we[1]), .bus_a(bus_a[1]), .bus_d(bus_d[1]), .busy(busy[1]),
        .done(done[1]), .wr_left(wr_left[1]), .state_dbg(state_dbg[1])
    );

    mmc1_serial_loader #(.STROBE_CYCLES(2), .GAP_CYCLES(1)) u2 (
        .ck(ck), .nres(nres), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_reg(req_reg[2]), .req_data(req_data[2]), .req_reset(req_reset[2]),
        .bus_we(bus_we[2]), .bus_a(bus_a[2]), .bus_d(bus_d[2]), .busy(busy[2]),
        .done(done[2]), .wr_left(wr_left[2]), .state_dbg(state_dbg[2])
    );

    function automatic int p_sc(input int i);
        return (i == 2) ? 2 : 1;
    endfunction
    function automatic int p_gc(input int i);
        return (i == 2) ? 1 : 2;
    endfunction
    function automatic int p_rf(input int i);
        return (i == 1) ? 0 : 1;
    endfunction

    // model: per-cycle expectation queue built from the list of writes
    exp_t       exp_q [3][$];
    logic [1:0] hold_a [3];
    logic [7:0] hold_d [3];

    task automatic push_seq(input int i, input logic rst, input logic [1:0] r,
                            input logic [4:0] dat);
        logic [7:0] w [$];
        exp_t e;
        int n_w;
        if (rst || p_rf(i) != 0) w.push_back(8'h80);
        if (!rst) for (int k = 0; k < 5; k++) w.push_back({7'b0, dat[k]});
        n_w = w.size();
        for (int n = 0; n < n_w; n++) begin
            for (int s = 0; s < p_sc(i); s++) begin
                e = '{1'b1, r, w[n], 3'(n_w - n), 1'b0, 1'b0};
                exp_q[i].push_back(e);
            end
            if (n < n_w - 1) begin
                for (int g = 0; g < p_gc(i); g++) begin
                    e = '{1'b0, r, w[n], 3'(n_w - n - 1), 1'b0, 1'b0};
                    exp_q[i].push_back(e);
                end
            end
        end
        e = '{1'b0, r, w[n_w - 1], 3'd0, 1'b1, 1'b0};
        exp_q[i].push_back(e);
    endtask

    // model advance on each active edge
    initial begin
        forever begin
            @(posedge ck);
            for (int i = 0; i < 3; i++) begin
                if (!nres) begin
                    exp_q[i].delete();
                    hold_a[i] = 2'd0;
                    hold_d[i] = 8'h00;
                end else if (exp_q[i].size() == 0) begin
                    if (req_valid[i]) push_seq(i, req_reset[i], req_reg[i], req_data[i]);
                end else begin
                    hold_a[i] = exp_q[i][0].a;
                    hold_d[i] = exp_q[i][0].d;
                    void'(exp_q[i].pop_front());
                end
            end
        end
    end

    // scoreboard compare, every cycle, away from the active edge
    initial begin
        exp_t ex;
        exp_t ac;
        forever begin
            @(negedge ck);
            if (chk_en) begin
                for (int i = 0; i < 3; i++) begin
                    if (exp_q[i].size() != 0) ex = exp_q[i][0];
                    else ex = '{1'b0, hold_a[i], hold_d[i], 3'd0, 1'b0, 1'b1};
                    ac = '{bus_we[i], bus_a[i], bus_d[i], wr_left[i], done[i], req_ready[i]};
                    vectors++;
                    if (ac !== ex || busy[i] !== ~ex.rdy) begin
                        miscompares++;
                        $display("FAIL cycle_u%0d t=%0t got we=%b a=%0d d=%h wl=%0d done=%b rdy=%b busy=%b want we=%b a=%0d d=%h wl=%0d done=%b rdy=%b busy=%b",
                                 i, $time, ac.we, ac.a, ac.d, ac.wl, ac.dn, ac.rdy, busy[i],
                                 ex.we, ex.a, ex.d, ex.wl, ex.dn, ex.rdy, ~ex.rdy);
                    end
                end
            end
        end
    end

    // literal checks
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d", nm, act, exp_v);
        end
    endtask

    task automatic chk_list(input string nm, input int got[$], input int want[$]);
        chk({nm, "_count"}, got.size(), want.size());
        for (int k = 0; k < want.size(); k++)
            chk($sformatf("%s[%0d]", nm, k), (k < got.size()) ? got[k] : -1, want[k]);
    endtask

    // driver / observer tasks
    int rise_q [$];
    int d_q [$];
    int a_q [$];
    int wl_q [$];
    int done_q [$];
    int ready_k;
    int want_q [$];
    logic prev_we;

    task automatic clear_obs();
        rise_q.delete(); d_q.delete(); a_q.delete(); wl_q.delete(); done_q.delete();
        ready_k = -1;
        prev_we = 1'b0;
    endtask

    task automatic observe(input int i, input int k0, input int k1);
        for (int k = k0; k <= k1; k++) begin
            @(negedge ck);
            if (bus_we[i] && !prev_we) begin
                rise_q.push_back(k);
                d_q.push_back(int'(bus_d[i]));
                a_q.push_back(int'(bus_a[i]));
                wl_q.push_back(int'(wr_left[i]));
            end
            if (done[i]) done_q.push_back(k);
            if (req_ready[i] && ready_k < 0 && done_q.size() != 0) ready_k = k;
            prev_we = bus_we[i];
        end
    endtask

    task automatic wait_idle(input int i);
        bit ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge ck);
            if (req_ready[i] === 1'b1) ok = 1'b1;
        end
        if (!ok) chk($sformatf("idle_timeout_u%0d", i), 0, 1);
    endtask

    task automatic launch(input int i, input logic rst, input logic [1:0] r,
                          input logic [4:0] dat, input logic keep);
        @(negedge ck);
        req_valid[i] = 1'b1;
        req_reset[i] = rst;
        req_reg[i]   = r;
        req_data[i]  = dat;
        @(posedge ck);
        #1;
        if (!keep) req_valid[i] = 1'b0;
        clear_obs();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        chk_en = 1'b0;
        nres = 1'b0;
        req_valid = '0;
        req_reset = '0;
        req_reg = '0;
        req_data = '0;
        repeat (2) @(posedge ck);
        chk_en = 1'b1;
        @(negedge ck);
        chk("reset_ready_u0", req_ready[0], 1);
        chk("reset_wl_u0", wr_left[0], 0);
        chk("reset_d_u0", bus_d[0], 0);
        nres = 1'b1;

        // defaults, reg 3, data 0x16
        wait_idle(0);
        launch(0, 1'b0, 2'd3, 5'h16, 1'b0);
        observe(0, 1, 20);
        want_q = '{1, 4, 7, 10, 13, 16};           chk_list("t1_rise", rise_q, want_q);
        want_q = '{128, 0, 1, 1, 0, 1};            chk_list("t1_d", d_q, want_q);
        want_q = '{3, 3, 3, 3, 3, 3};              chk_list("t1_a", a_q, want_q);
        want_q = '{6, 5, 4, 3, 2, 1};              chk_list("t1_wl", wl_q, want_q);
        want_q = '{17};                            chk_list("t1_done", done_q, want_q);
        chk("t1_ready", ready_k, 18);

        // no reset write, reg 0, data 0x1F
        wait_idle(1);
        launch(1, 1'b0, 2'd0, 5'h1F, 1'b0);
        observe(1, 1, 16);
        want_q = '{1, 4, 7, 10, 13};               chk_list("t2_rise", rise_q, want_q);
        want_q = '{1, 1, 1, 1, 1};                 chk_list("t2_d", d_q, want_q);
        want_q = '{5, 4, 3, 2, 1};                 chk_list("t2_wl", wl_q, want_q);
        want_q = '{14};                            chk_list("t2_done", done_q, want_q);

        // reset-only request, data ignored
        wait_idle(0);
        launch(0, 1'b1, 2'd2, 5'h0A, 1'b0);
        observe(0, 1, 5);
        want_q = '{1};                             chk_list("t3_rise", rise_q, want_q);
        want_q = '{128};                           chk_list("t3_d", d_q, want_q);
        want_q = '{2};                             chk_list("t3_a", a_q, want_q);
        want_q = '{2};                             chk_list("t3_done", done_q, want_q);
        req_reset[0] = 1'b0;

        // back-to-back with req_valid held; fields change while busy
        wait_idle(0);
        launch(0, 1'b0, 2'd1, 5'h05, 1'b1);
        req_reg[0]  = 2'd3;
        req_data[0] = 5'h1A;
        observe(0, 1, 18);
        @(posedge ck);
        #1;
        req_valid[0] = 1'b0;
        observe(0, 19, 37);
        want_q = '{1, 4, 7, 10, 13, 16, 19, 22, 25, 28, 31, 34};
        chk_list("t4_rise", rise_q, want_q);
        want_q = '{128, 1, 0, 1, 0, 0, 128, 0, 1, 0, 1, 1};
        chk_list("t4_d", d_q, want_q);
        want_q = '{1, 1, 1, 1, 1, 1, 3, 3, 3, 3, 3, 3};
        chk_list("t4_a", a_q, want_q);
        want_q = '{17, 35};                        chk_list("t4_done", done_q, want_q);

        // 2-cycle strobes, 1-cycle gaps, data 0
        wait_idle(2);
        launch(2, 1'b0, 2'd1, 5'h00, 1'b0);
        observe(2, 1, 20);
        want_q = '{1, 4, 7, 10, 13, 16};           chk_list("t5_rise", rise_q, want_q);
        want_q = '{128, 0, 0, 0, 0, 0};            chk_list("t5_d", d_q, want_q);
        want_q = '{18};                            chk_list("t5_done", done_q, want_q);

        // reset during the third strobe, then a full recovery sequence
        wait_idle(0);
        launch(0, 1'b0, 2'd2, 5'h13, 1'b0);
        observe(0, 1, 7);
        want_q = '{1, 4, 7};                       chk_list("t6_rise_pre", rise_q, want_q);
        nres = 1'b0;
        @(negedge ck);
        chk("t6_we", bus_we[0], 0);
        chk("t6_d", bus_d[0], 0);
        chk("t6_wl", wr_left[0], 0);
        chk("t6_ready", req_ready[0], 1);
        nres = 1'b1;
        wait_idle(0);
        launch(0, 1'b0, 2'd1, 5'h0B, 1'b0);
        observe(0, 1, 20);
        want_q = '{1, 4, 7, 10, 13, 16};           chk_list("t6_rise", rise_q, want_q);
        want_q = '{128, 1, 1, 0, 1, 0};            chk_list("t6_dlist", d_q, want_q);
        want_q = '{17};                            chk_list("t6_done", done_q, want_q);

        repeat (3) @(negedge ck);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
